// File: rtl/rc5_pkg.sv
// Shared types, RC5 magic constants and rotate helpers for the RC5 round engine.
// The decrypt datapath is built only when RC5_DECRYPT_EN is defined.
package rc5_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRound,
        StDone
    } rc5_state_e;

    localparam logic [15:0] P16 = 16'hB7E1;
    localparam logic [15:0] Q16 = 16'h9E37;
    localparam logic [31:0] P32 = 32'hB7E15163;
    localparam logic [31:0] Q32 = 32'h9E3779B9;
    localparam logic [63:0] P64 = 64'hB7E151628AED2A6B;
    localparam logic [63:0] Q64 = 64'h9E3779B97F4A7C15;

    // Operands live in the low w bits of a 64-bit container; amt must be < w.
    function automatic logic [63:0] rotl(input logic [63:0] x, input int unsigned w,
                                         input logic [5:0] amt);
        logic [63:0] mask;
        logic [63:0] xm;
        mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        xm   = x & mask;
        if (amt == 6'd0) begin
            return xm;
        end
        return ((xm << amt) | (xm >> (w - 32'(amt)))) & mask;
    endfunction

    function automatic logic [63:0] rotr(input logic [63:0] x, input int unsigned w,
                                         input logic [5:0] amt);
        logic [63:0] mask;
        logic [63:0] xm;
        mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        xm   = x & mask;
        if (amt == 6'd0) begin
            return xm;
        end
        return ((xm >> amt) | (xm << (w - 32'(amt)))) & mask;
    endfunction

endpackage

// File: rtl/rc5_round_engine_round.sv
// Combinational single RC5 round; decrypt half present only with RC5_DECRYPT_EN.
module rc5_round #(
    parameter int unsigned W   = 32,
    parameter int unsigned LGW = $clog2(W)
) (
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic [W-1:0]   s_even,
    input  logic [W-1:0]   s_odd,
    input  logic           mode,
    output logic [2*W-1:0] ab_next
);
    import rc5_pkg::*;

    function automatic logic [W-1:0] rl(input logic [W-1:0] x, input logic [LGW-1:0] s);
        logic [63:0] xe;
        logic [63:0] r;
        logic [5:0]  se;
        xe         = '0;
        se         = '0;
        xe[W-1:0]  = x;
        se[LGW-1:0] = s;
        r          = rotl(xe, W, se);
        return r[W-1:0];
    endfunction

    function automatic logic [W-1:0] rr(input logic [W-1:0] x, input logic [LGW-1:0] s);
        logic [63:0] xe;
        logic [63:0] r;
        logic [5:0]  se;
        xe         = '0;
        se         = '0;
        xe[W-1:0]  = x;
        se[LGW-1:0] = s;
        r          = rotr(xe, W, se);
        return r[W-1:0];
    endfunction

    logic [W-1:0] a_enc, b_enc;

`ifdef RC5_DECRYPT_EN
    logic [W-1:0] a_dec, b_dec;

    always_comb begin
        a_enc   = rl(a ^ b, b[LGW-1:0]) + s_even;
        b_enc   = rl(b ^ a_enc, a_enc[LGW-1:0]) + s_odd;
        b_dec   = rr(b - s_odd, a[LGW-1:0]) ^ a;
        a_dec   = rr(a - s_even, b_dec[LGW-1:0]) ^ b_dec;
        ab_next = mode ? {a_dec, b_dec} : {a_enc, b_enc};
    end
`else
    logic unused_mode;
    assign unused_mode = mode;

    always_comb begin
        a_enc   = rl(a ^ b, b[LGW-1:0]) + s_even;
        b_enc   = rl(b ^ a_enc, a_enc[LGW-1:0]) + s_odd;
        ab_next = {a_enc, b_enc};
    end
`endif

endmodule

// File: rtl/rc5_round_engine.sv
// Iterative RC5-W/R core: one round per clock, runtime key table, valid/ready handshakes.
// Define RC5_DECRYPT_EN to build the decrypt path; otherwise every block is encrypted.
module rc5_round_engine #(
    parameter int unsigned W = 32,
    parameter int unsigned R = 12
) (
    input  logic           clk,
    input  logic           clr,
    input  logic           din_vld,
    output logic           din_rdy,
    input  logic [2*W-1:0] din,
    input  logic           mode,
    output logic           dout_vld,
    input  logic           dout_rdy,
    output logic [2*W-1:0] dout,
    input  logic           skey_we,
    input  logic [7:0]     skey_addr,
    input  logic [W-1:0]   skey_wdata,
    output logic           busy
);
    import rc5_pkg::*;

    localparam int unsigned LGW  = $clog2(W);
    localparam int unsigned T    = 2 * R + 2;
    localparam int unsigned IdxW = $clog2(T);
    localparam logic [9:0]  TCnt = 10'(T);

    rc5_state_e   state_q, state_d;
    logic [7:0]   i_q, i_d;
    logic [W-1:0] a_q, a_d, b_q, b_d;
    logic [W-1:0] skey_q [T];

    logic            key_wr;
    logic [IdxW-1:0] ev_idx, od_idx;
    logic [W-1:0]    s0_acc, s1_acc;
    logic [2*W-1:0]  round_ab;
    logic            dec_q;

`ifdef RC5_DECRYPT_EN
    logic dec_d;
`else
    logic unused_mode;
    assign unused_mode = mode;
    assign dec_q       = 1'b0;
`endif

    assign key_wr = (state_q == StIdle) && skey_we && ({2'b00, skey_addr} < TCnt);

    // A key write coinciding with an accept must already be seen by the pre-whitening add.
    assign s0_acc = (key_wr && skey_addr == 8'd0) ? skey_wdata : skey_q[0];
    assign s1_acc = (key_wr && skey_addr == 8'd1) ? skey_wdata : skey_q[1];

    assign ev_idx = IdxW'({i_q, 1'b0});
    assign od_idx = {ev_idx[IdxW-1:1], 1'b1};

    rc5_round #(
        .W   (W),
        .LGW (LGW)
    ) u_round (
        .a       (a_q),
        .b       (b_q),
        .s_even  (skey_q[ev_idx]),
        .s_odd   (skey_q[od_idx]),
        .mode    (dec_q),
        .ab_next (round_ab)
    );

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        a_d     = a_q;
        b_d     = b_q;
`ifdef RC5_DECRYPT_EN
        dec_d   = dec_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (din_vld) begin
                    state_d = StRound;
`ifdef RC5_DECRYPT_EN
                    dec_d   = mode;
                    if (mode) begin
                        a_d = din[2*W-1:W];
                        b_d = din[W-1:0];
                        i_d = 8'(R);
                    end else begin
                        a_d = din[2*W-1:W] + s0_acc;
                        b_d = din[W-1:0] + s1_acc;
                        i_d = 8'd1;
                    end
`else
                    a_d = din[2*W-1:W] + s0_acc;
                    b_d = din[W-1:0] + s1_acc;
                    i_d = 8'd1;
`endif
                end
            end
            StRound: begin
                a_d = round_ab[2*W-1:W];
                b_d = round_ab[W-1:0];
                if (dec_q) begin
                    if (i_q == 8'd1) begin
                        // Post-round whitening folded into the last decrypt round.
                        a_d     = round_ab[2*W-1:W] - skey_q[0];
                        b_d     = round_ab[W-1:0] - skey_q[1];
                        state_d = StDone;
                    end else begin
                        i_d = i_q - 8'd1;
                    end
                end else begin
                    if (i_q == 8'(R)) begin
                        state_d = StDone;
                    end else begin
                        i_d = i_q + 8'd1;
                    end
                end
            end
            StDone: begin
                if (dout_rdy) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= StIdle;
            i_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

`ifdef RC5_DECRYPT_EN
    always_ff @(posedge clk) begin
        if (clr) begin
            dec_q <= 1'b0;
        end else begin
            dec_q <= dec_d;
        end
    end
`endif

    // Key table is deliberately not cleared by clr.
    always_ff @(posedge clk) begin
        if (key_wr && !clr) begin
            skey_q[IdxW'(skey_addr)] <= skey_wdata;
        end
    end

    assign din_rdy  = (state_q == StIdle);
    assign dout_vld = (state_q == StDone);
    assign busy     = (state_q != StIdle);
    assign dout     = {a_q, b_q};

endmodule
